// File: rtl/rs_enc_ctrl_if.sv
`timescale 1ns/1ps
// Message-in / codeword-out stream bundle for the RS encoder frame sequencer.
// The slave modport is the controller's view and the master modport is the producer/consumer side.
interface rs_enc_ctrl_if #(
    parameter int SW = 8
);
    logic          s_valid;
    logic [SW-1:0] s_data;
    logic          s_last;
    logic          s_ready;
    logic          m_valid;
    logic [SW-1:0] m_data;
    logic          m_last;
    logic          m_ready;

    modport slave (
        input  s_valid, s_data, s_last, m_ready,
        output s_ready, m_valid, m_data, m_last
    );

    modport master (
        output s_valid, s_data, s_last, m_ready,
        input  s_ready, m_valid, m_data, m_last
    );
endinterface

// File: rtl/rs_enc_ctrl.sv
`timescale 1ns/1ps
// Frame sequencer for a systematic RS(N,K) GF(2^8) LFSR encoder: passes up to K message
// symbols straight through while feeding the taps, then drains N-K parity symbols from the top stage.
module rs_enc_ctrl #(
    parameter int N  = 255,
    parameter int K  = 239,
    parameter int SW = 8
) (
    input  logic          i_clk,
    input  logic          i_rst,
    rs_enc_ctrl_if.slave  bus,
    input  logic [SW-1:0] i_r_top,
    output logic [SW-1:0] o_fb_data,
    output logic          o_cw_en,
    output logic          o_reg_clr,
    output logic          o_frame_err,
    output logic          o_busy
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MSG  = 2'd1,
        ST_PAR  = 2'd2
    } state_t;

    localparam logic [7:0] MSG_LAST = 8'(K - 1);
    localparam logic [7:0] PAR_LAST = 8'(N - K - 1);

    state_t     r_state;
    logic [7:0] r_cnt;
    logic       r_frame_err;
    logic       w_msg_xfer;
    logic       w_par_xfer;

    assign w_msg_xfer = (r_state == ST_MSG) && bus.s_valid && bus.m_ready;
    assign w_par_xfer = (r_state == ST_PAR) && bus.m_ready;

    // Phase sequencing, transfer counting and the registered length-violation pulse.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 8'd0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_state <= ST_MSG;
                    r_cnt   <= 8'd0;
                end
                ST_MSG: begin
                    if (w_msg_xfer) begin
                        if (r_cnt == MSG_LAST) begin
                            // The frame closes at K symbols whether or not s_last came with it.
                            r_state     <= ST_PAR;
                            r_cnt       <= 8'd0;
                            r_frame_err <= ~bus.s_last;
                        end else if (bus.s_last) begin
                            r_state     <= ST_PAR;
                            r_cnt       <= 8'd0;
                            r_frame_err <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 8'd1;
                        end
                    end
                end
                ST_PAR: begin
                    if (w_par_xfer) begin
                        if (r_cnt == PAR_LAST) begin
                            r_state <= ST_IDLE;
                            r_cnt   <= 8'd0;
                        end else begin
                            r_cnt <= r_cnt + 8'd1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= 8'd0;
                end
            endcase
        end
    end

    // Output decode from the registered phase; the message path is a zero-latency pass-through.
    always_comb begin
        bus.s_ready = 1'b0;
        bus.m_valid = 1'b0;
        bus.m_data  = '0;
        bus.m_last  = 1'b0;
        o_fb_data   = '0;
        o_cw_en     = 1'b0;
        o_reg_clr   = 1'b0;
        o_frame_err = 1'b0;
        o_busy      = 1'b0;
        if (i_rst) begin
            o_busy = 1'b0;
        end else begin
            o_frame_err = r_frame_err;
            case (r_state)
                ST_IDLE: begin
                    o_reg_clr = 1'b1;
                end
                ST_MSG: begin
                    bus.s_ready = bus.m_ready;
                    bus.m_valid = bus.s_valid;
                    bus.m_data  = bus.s_data;
                    o_fb_data   = bus.s_data ^ i_r_top;
                    o_cw_en     = w_msg_xfer;
                    o_busy      = 1'b1;
                end
                ST_PAR: begin
                    bus.m_valid = 1'b1;
                    bus.m_data  = i_r_top;
                    bus.m_last  = (r_cnt == PAR_LAST);
                    o_cw_en     = w_par_xfer;
                    o_busy      = 1'b1;
                end
                default: begin
                    o_busy = 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_rs_enc_ctrl.sv
`timescale 1ns/1ps
// Self-checking bench for rs_enc_ctrl: behavioural GF(2^8) LFSR datapath drives r_top,
// and a long-division golden encoder supplies the expected parity symbols.
module tb_rs_enc_ctrl;
    localparam int N = 255;
    localparam int K = 239;
    localparam int P = N - K;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rs_enc_ctrl_if #(.SW(8)) bus ();

    logic [7:0] r_top;
    logic [7:0] fb_data;
    logic       cw_en;
    logic       reg_clr;
    logic       frame_err;
    logic       busy;
    logic       ovr_en  = 1'b0;
    logic [7:0] ovr_val = 8'h00;

    logic [7:0] dp      [P];
    logic [7:0] gen     [P+1];
    logic [7:0] msg     [K];
    logic [7:0] exp_par [P];
    logic [7:0] got     [$];
    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       rst;
        logic       sv;
        logic [7:0] sd;
        logic       sl;
        logic       mr;
        logic [7:0] rt;
        logic       e_sready;
        logic       e_mvalid;
        logic [7:0] e_mdata;
        logic [7:0] e_fb;
        logic       e_cw;
        logic       e_busy;
    } vec_t;
    vec_t tbl [6];

    rs_enc_ctrl #(.N(N), .K(K), .SW(8)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .bus         (bus),
        .i_r_top     (r_top),
        .o_fb_data   (fb_data),
        .o_cw_en     (cw_en),
        .o_reg_clr   (reg_clr),
        .o_frame_err (frame_err),
        .o_busy      (busy)
    );

    assign r_top = ovr_en ? ovr_val : dp[P-1];

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1D) : (aa << 1);
        end
        return p;
    endfunction

    // Parity-stage chain: every stage advances together on cw_en.
    always @(posedge clk) begin
        if (reg_clr) begin
            for (int i = 0; i < P; i++) dp[i] <= 8'h00;
        end else if (cw_en) begin
            dp[0] <= gf_mul(fb_data, gen[0]);
            for (int i = 1; i < P; i++) dp[i] <= dp[i-1] ^ gf_mul(fb_data, gen[i]);
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic golden(input int len);
        logic [7:0] b [K+P];
        logic [7:0] c;
        for (int i = 0; i < K + P; i++) begin
            if (i < len) b[i] = msg[i];
            else         b[i] = 8'h00;
        end
        for (int j = 0; j < len; j++) begin
            c = b[j];
            for (int t = 1; t <= P; t++) b[j+t] = b[j+t] ^ gf_mul(c, gen[P-t]);
        end
        for (int i = 0; i < P; i++) exp_par[i] = b[len+i];
    endtask

    task automatic idle_check(input string nm);
        @(negedge clk);
        rst         = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        bus.s_data  = 8'h00;
        bus.m_ready = 1'b1;
        #1;
        chk({nm, "_idle"}, {59'd0, reg_clr, busy, bus.m_valid, bus.s_ready, cw_en}, {59'd0, 5'b10000});
    endtask

    // len message symbols offered; s_last on index last_pos (-1: never); abort_beat >= 0 resets mid-frame.
    task automatic run_frame(input string nm, input int len, input int last_pos, input bit bp, input int abort_beat);
        int idx, nb, cwn, nmis, first_bad;
        bit ferr_exp, pend, xfer, prev_hold, done;
        logic [7:0] prev_data;
        logic [7:0] e;
        idle_check(nm);
        golden(len);
        got.delete();
        idx = 0; nb = 0; cwn = 0;
        ferr_exp = 1'b0; pend = 1'b0; prev_hold = 1'b0; done = 1'b0;
        prev_data = 8'h00;
        for (int cyc = 0; cyc < 4000 && !done; cyc++) begin
            @(negedge clk);
            bus.m_ready = bp ? (cyc % 2 == 0) : 1'b1;
            if (!pend) bus.s_valid = (idx < len) && (!bp || $urandom_range(0, 2) != 0);
            bus.s_data = (idx < len) ? msg[idx] : 8'h00;
            bus.s_last = (idx == last_pos);
            if (abort_beat >= 0 && nb == abort_beat) begin
                rst = 1'b1;
                #1;
                chk({nm, "_abort"}, {60'd0, bus.m_valid, busy, bus.m_last, cw_en}, 64'd0);
                return;
            end
            #1;
            chk({nm, "_ferr"}, {63'd0, frame_err}, {63'd0, ferr_exp});
            chk({nm, "_busy"}, {63'd0, busy}, 64'd1);
            xfer = bus.m_valid && bus.m_ready;
            chk({nm, "_cw_xfer"}, {63'd0, cw_en}, {63'd0, xfer});
            if (prev_hold) chk({nm, "_hold"}, {55'd0, bus.m_valid, bus.m_data}, {55'd0, 1'b1, prev_data});
            prev_hold = bus.m_valid && !bus.m_ready;
            prev_data = bus.m_data;
            if (cw_en) cwn++;
            ferr_exp = 1'b0;
            if (bus.s_valid && bus.s_ready) begin
                if (idx < K - 1 && bus.s_last) ferr_exp = 1'b1;
                if (idx == K - 1 && !bus.s_last) ferr_exp = 1'b1;
                idx++;
            end
            pend = bus.s_valid && !bus.s_ready;
            if (xfer) begin
                got.push_back(bus.m_data);
                chk({nm, "_m_last"}, {63'd0, bus.m_last}, {63'd0, (nb == len + P - 1)});
                nb++;
                if (nb == len + P) done = 1'b1;
            end
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: got %0d beats expected %0d", nm, nb, len + P);
        end
        chk({nm, "_beats"}, nb, len + P);
        chk({nm, "_cw_cnt"}, cwn, len + P);
        nmis = 0;
        first_bad = -1;
        for (int i = 0; i < got.size(); i++) begin
            e = (i < len) ? msg[i] : exp_par[i-len];
            if (got[i] !== e) begin
                nmis++;
                if (first_bad < 0) begin
                    first_bad = i;
                    $display("note %s: first differing beat %0d got %0h expected %0h", nm, i, got[i], e);
                end
            end
        end
        chk({nm, "_seq"}, nmis, 0);
    endtask

    initial begin
        bus.s_valid = 1'b0;
        bus.s_data  = 8'h00;
        bus.s_last  = 1'b0;
        bus.m_ready = 1'b0;

        for (int j = 0; j <= P; j++) gen[j] = 8'h00;
        gen[0] = 8'h01;
        begin
            logic [7:0] alpha;
            alpha = 8'h01;
            for (int i = 0; i < P; i++) begin
                for (int j = P; j >= 1; j--) gen[j] = gen[j-1] ^ gf_mul(gen[j], alpha);
                gen[0] = gf_mul(gen[0], alpha);
                alpha  = gf_mul(alpha, 8'h02);
            end
        end

        //          rst   sv    sd     sl    mr    rt     srdy  mval  mdata  fb     cw    busy
        tbl[0] = '{1'b0, 1'b1, 8'hA5, 1'b0, 1'b1, 8'h3C, 1'b1, 1'b1, 8'hA5, 8'h99, 1'b1, 1'b1};
        tbl[1] = '{1'b0, 1'b0, 8'h5A, 1'b0, 1'b1, 8'h0F, 1'b1, 1'b0, 8'h5A, 8'h55, 1'b0, 1'b1};
        tbl[2] = '{1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1, 8'hFF, 8'h00, 1'b0, 1'b1};
        tbl[3] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h81, 1'b0, 1'b0, 8'h00, 8'h81, 1'b0, 1'b1};
        tbl[4] = '{1'b1, 1'b1, 8'h77, 1'b1, 1'b1, 8'h12, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 1'b1, 8'h12, 1'b1, 1'b1, 8'h34, 1'b1, 1'b1, 8'h12, 8'h26, 1'b1, 1'b1};

        // Reset held with traffic offered: every output must stay low.
        ovr_en  = 1'b1;
        ovr_val = 8'hC3;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            rst         = 1'b1;
            bus.s_valid = 1'b1;
            bus.s_data  = 8'h5A;
            bus.s_last  = 1'b1;
            bus.m_ready = 1'b1;
            #1;
            chk("rst_out", {40'd0, bus.s_ready, bus.m_valid, bus.m_last, bus.m_data, fb_data, cw_en, reg_clr, frame_err, busy},
                64'd0);
        end
        idle_check("post_rst");

        // Combinational MSG-phase vectors; inputs are withdrawn before each edge so nothing transfers.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            rst         = tbl[i].rst;
            bus.s_valid = tbl[i].sv;
            bus.s_data  = tbl[i].sd;
            bus.s_last  = tbl[i].sl;
            bus.m_ready = tbl[i].mr;
            ovr_val     = tbl[i].rt;
            #1;
            chk($sformatf("vec%0d", i),
                {41'd0, bus.s_ready, bus.m_valid, bus.m_data, fb_data, cw_en, busy, reg_clr, bus.m_last, frame_err},
                {41'd0, tbl[i].e_sready, tbl[i].e_mvalid, tbl[i].e_mdata, tbl[i].e_fb, tbl[i].e_cw, tbl[i].e_busy, 3'b000});
            #1;
            rst         = 1'b0;
            bus.s_valid = 1'b0;
        end
        @(negedge clk);
        rst    = 1'b1;
        ovr_en = 1'b0;

        for (int i = 0; i < K; i++) msg[i] = 8'h00;
        run_frame("zeros", K, K - 1, 1'b0, -1);

        for (int i = 0; i < K; i++) msg[i] = 8'(i + 1);
        run_frame("ramp", K, K - 1, 1'b0, -1);
        run_frame("ramp_bp", K, K - 1, 1'b1, -1);
        run_frame("short", 100, 99, 1'b0, -1);
        run_frame("nolast", K, -1, 1'b0, -1);
        run_frame("abort", K, K - 1, 1'b0, K + 4);
        run_frame("after_abort", K, K - 1, 1'b0, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
